// File: rtl/clkdiv_sched.sv
// Run-time clock divider controller: start/stop sequencing, tick/div_out generation,
// and divisor reconfiguration deferred to period boundaries so outputs never glitch.
module clkdiv_sched #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             running,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] phase, phase_nxt;
    logic [WIDTH-1:0] cur_div_nxt;
    logic [WIDTH-1:0] pend_div, pend_div_nxt;
    logic             stop_req, stop_req_nxt;
    logic             cfg_err_nxt;
    logic             last;
    logic             xfer;
    logic             cfg_ok;
    logic             stop_now;

    assign cfg_ready = (state != PEND);
    assign running   = (state != IDLE);
    assign last      = (phase == cur_div - WIDTH'(1));
    assign tick      = running & last;
    assign div_out   = running & (phase < (cur_div >> 1));
    assign xfer      = cfg_valid & cfg_ready;
    assign cfg_ok    = (cfg_div >= WIDTH'(2));
    assign stop_now  = stop_req | stop;

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        stop_req_nxt = stop_req;
        cfg_err_nxt  = xfer & ~cfg_ok;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (xfer && cfg_ok) cur_div_nxt = cfg_div;
                if (start && !stop) state_nxt = RUN;
            end
            RUN: begin
                phase_nxt = last ? '0 : phase + WIDTH'(1);
                if (xfer && cfg_ok) pend_div_nxt = cfg_div;
                if (last && stop_now) begin
                    // Halting at this boundary: a divisor offered now can be applied directly.
                    state_nxt    = IDLE;
                    stop_req_nxt = 1'b0;
                    if (xfer && cfg_ok) cur_div_nxt = cfg_div;
                end else begin
                    stop_req_nxt = stop_now;
                    if (xfer && cfg_ok) state_nxt = PEND;
                end
            end
            PEND: begin
                phase_nxt = last ? '0 : phase + WIDTH'(1);
                if (last) begin
                    cur_div_nxt  = pend_div;
                    stop_req_nxt = 1'b0;
                    state_nxt    = stop_now ? IDLE : RUN;
                end else begin
                    stop_req_nxt = stop_now;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            cur_div  <= WIDTH'(DEFAULT_DIV);
            pend_div <= '0;
            stop_req <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            cur_div  <= cur_div_nxt;
            pend_div <= pend_div_nxt;
            stop_req <= stop_req_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Scoreboard bench for clkdiv_sched: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_clkdiv_sched;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;
    logic         running;
    logic         tick;
    logic         div_out;
    logic [W-1:0] cur_div;

    clkdiv_sched #(
        .WIDTH       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .running   (running),
        .tick      (tick),
        .div_out   (div_out),
        .cur_div   (cur_div)
    );

    typedef struct {
        int           cyc;
        int           id;
        logic         run;
        logic         tk;
        logic         dv;
        logic         rdy;
        logic         err;
        logic [W-1:0] div;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   tid   = 0;
    bit   flush = 1'b0;
    event chk_now;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input int id, input int c, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL t%0d.%s cyc=%0d got=%0b want=%0b", id, name, c, got, want);
        end
    endtask

    task automatic check_div(input int id, input int c, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL t%0d.cur_div cyc=%0d got=%0d want=%0d", id, c, got, want);
        end
    endtask

    // cyc = -1 entries are checked immediately on chk_now (async reset checks)
    always @(negedge clk or chk_now) begin
        while (sb.size() != 0 && (flush || sb[0].cyc <= cyc)) begin
            mon_e = sb.pop_front();
            if (flush || (mon_e.cyc >= 0 && mon_e.cyc < cyc)) begin
                total++;
                bad++;
                $display("FAIL t%0d.missed cyc=%0d now=%0d", mon_e.id, mon_e.cyc, cyc);
            end else begin
                check_bit("running", mon_e.id, mon_e.cyc, running, mon_e.run);
                check_bit("tick", mon_e.id, mon_e.cyc, tick, mon_e.tk);
                check_bit("div_out", mon_e.id, mon_e.cyc, div_out, mon_e.dv);
                check_bit("cfg_ready", mon_e.id, mon_e.cyc, cfg_ready, mon_e.rdy);
                check_bit("cfg_err", mon_e.id, mon_e.cyc, cfg_err, mon_e.err);
                check_div(mon_e.id, mon_e.cyc, cur_div, mon_e.div);
            end
        end
    end

    task automatic push_one(input int c, input int r, input int t, input int d, input int y, input int er,
                            input int unsigned dv);
        exp_t e;
        e.cyc = c;
        e.id  = tid;
        e.run = (r != 0);
        e.tk  = (t != 0);
        e.dv  = (d != 0);
        e.rdy = (y != 0);
        e.err = (er != 0);
        e.div = dv;
        sb.push_back(e);
    endtask

    // Running cycles from c onward; one character per cycle for tick, div_out, cfg_ready
    task automatic push_pat(input int c, input string tk, input string dv, input string rd, input int unsigned div);
        for (int unsigned i = 0; i < unsigned'(tk.len()); i++) begin
            push_one(c + int'(i), 1,
                     (tk.getc(int'(i)) == "1") ? 1 : 0,
                     (dv.getc(int'(i)) == "1") ? 1 : 0,
                     (rd.getc(int'(i)) == "1") ? 1 : 0,
                     0, div);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic check_now();
        ->chk_now;
        #1;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 200 && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            flush = 1'b1;
            check_now();
            flush = 1'b0;
        end
    endtask

    task automatic do_reset();
        drain();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        step(2);
        tid = 0;
        push_one(-1, 0, 0, 0, 1, 0, 4);
        check_now();
        rst = 1'b0;
        step(1);

        // start with DIV=4, then offer 6 at phase 1 of the third period
        tid = 1;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 4);
        push_pat(b + 1, "00010001", "11001100", "11111111", 4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tid = 2;
        push_pat(b + 9, "0001", "1100", "1100", 4);
        push_pat(b + 13, "000001000001", "111000111000", "111111111111", 6);
        goto(b + 10);
        cfg_valid = 1'b1;
        cfg_div   = 6;
        step(1);
        cfg_valid = 1'b0;
        do_reset();

        // idle config: divisor 1 rejected, divisor 5 accepted then run
        tid = 3;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 4);
        push_one(b + 1, 0, 0, 0, 1, 1, 4);
        push_one(b + 2, 0, 0, 0, 1, 0, 4);
        push_one(b + 3, 0, 0, 0, 1, 0, 5);
        push_pat(b + 4, "0000100001", "1100011000", "1111111111", 5);
        cfg_valid = 1'b1;
        cfg_div   = 1;
        step(1);
        cfg_valid = 1'b0;
        step(1);
        cfg_valid = 1'b1;
        cfg_div   = 5;
        step(1);
        cfg_valid = 1'b0;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        do_reset();

        // start together with cfg 8, stop at phase 2, start while running ignored
        tid = 4;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 4);
        push_pat(b + 1, "00000001", "11110000", "11111111", 8);
        for (int unsigned i = 9; i <= 12; i++) push_one(b + int'(i), 0, 0, 0, 1, 0, 8);
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 8;
        step(1);
        start     = 1'b0;
        cfg_valid = 1'b0;
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        drain();

        // start&stop together stays idle; stop+cfg(3) in one RUN cycle
        tid = 5;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 8);
        push_one(b + 1, 0, 0, 0, 1, 0, 8);
        push_one(b + 2, 0, 0, 0, 1, 0, 8);
        push_pat(b + 3, "00000001", "11110000", "11000000", 8);
        push_one(b + 11, 0, 0, 0, 1, 0, 3);
        push_one(b + 12, 0, 0, 0, 1, 0, 3);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        stop      = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 3;
        step(1);
        stop      = 1'b0;
        cfg_valid = 1'b0;
        drain();

        // stop raised in the tick cycle halts at that boundary
        tid = 6;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 3);
        push_pat(b + 1, "001", "100", "111", 3);
        push_one(b + 4, 0, 0, 0, 1, 0, 3);
        push_one(b + 5, 0, 0, 0, 1, 0, 3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        drain();

        // async reset mid-period while a divisor change is pending
        tid = 7;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 3);
        push_pat(b + 1, "0", "1", "1", 3);
        start = 1'b1;
        step(1);
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 9;
        step(1);
        cfg_valid = 1'b0;
        push_one(-1, 1, 0, 0, 0, 0, 3);
        check_now();
        rst = 1'b1;
        #1;
        push_one(-1, 0, 0, 0, 1, 0, 4);
        check_now();
        step(1);
        rst = 1'b0;
        b = cyc;
        push_one(b, 0, 0, 0, 1, 0, 4);
        push_pat(b + 1, "00010001", "11001100", "11111111", 4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
